// File: rtl/rsa_mexp_ctrl_if.sv
// Handshake and data bundle between the register bank, the exponentiation sequencer
// and the shared Montgomery multiplier.
interface rsa_mexp_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_cmd;
  logic             stop_cmd;
  logic [WIDTH-1:0] rsa_p;
  logic [WIDTH-1:0] rsa_e;
  logic [WIDTH-1:0] rsa_m;
  logic [WIDTH-1:0] rsa_const;
  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic [WIDTH-1:0] mm_n;
  logic [WIDTH-1:0] mm_result;
  logic             mm_done;
  logic [WIDTH-1:0] rsa_c;
  logic             eoc;
  logic             busy;

  // Environment side: register bank plus multiplier.
  modport master (
    output start_cmd, stop_cmd, rsa_p, rsa_e, rsa_m, rsa_const, mm_result, mm_done,
    input  mm_start, mm_a, mm_b, mm_n, rsa_c, eoc, busy
  );

  // Sequencer side.
  modport slave (
    input  start_cmd, stop_cmd, rsa_p, rsa_e, rsa_m, rsa_const, mm_result, mm_done,
    output mm_start, mm_a, mm_b, mm_n, rsa_c, eoc, busy
  );
endinterface

// File: rtl/rsa_mexp_ctrl.sv
// Modular-exponentiation sequencer: drives a Montgomery multiplier through conversion,
// left-to-right square-and-multiply over E and back-conversion, returning M^E mod P.
module rsa_mexp_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  rsa_mexp_ctrl_if.slave bus
);
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle, StPreM, StPreX, StSqr, StMul, StPost, StDrain
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d, e_q, e_d, m_q, m_d, k_q, k_d;
  logic [WIDTH-1:0] x_q, x_d, mb_q, mb_d, a_q, a_d, b_q, b_d, c_q, c_d;
  logic [IW-1:0]    i_q, i_d;
  logic             start_q, start_d, eoc_q, eoc_d, busy_q, busy_d;
  logic             issue;
  logic [WIDTH-1:0] one;

  assign one = WIDTH'(1);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    e_d     = e_q;
    m_d     = m_q;
    k_d     = k_q;
    x_d     = x_q;
    mb_d    = mb_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    i_d     = i_q;
    eoc_d   = eoc_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    issue   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Stop has priority over a coincident start.
        if (!bus.stop_cmd && bus.start_cmd) begin
          p_d     = bus.rsa_p;
          e_d     = bus.rsa_e;
          m_d     = bus.rsa_m;
          k_d     = bus.rsa_const;
          i_d     = IW'(WIDTH - 1);
          eoc_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StPreM;
          issue   = 1'b1;
        end
      end
      StDrain: begin
        if (bus.mm_done) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        // Every operation state has a multiply in flight until mm_done is seen.
        if (bus.stop_cmd) begin
          state_d = bus.mm_done ? StIdle : StDrain;
          busy_d  = !bus.mm_done;
        end else if (bus.mm_done) begin
          issue = 1'b1;
          unique case (state_q)
            StPreM: begin
              mb_d    = bus.mm_result;
              state_d = StPreX;
            end
            StPreX: begin
              x_d     = bus.mm_result;
              state_d = StSqr;
            end
            StSqr: begin
              x_d = bus.mm_result;
              if (e_q[i_q]) begin
                state_d = StMul;
              end else if (i_q == '0) begin
                state_d = StPost;
              end else begin
                i_d     = i_q - IW'(1);
                state_d = StSqr;
              end
            end
            StMul: begin
              x_d = bus.mm_result;
              if (i_q == '0) begin
                state_d = StPost;
              end else begin
                i_d     = i_q - IW'(1);
                state_d = StSqr;
              end
            end
            StPost: begin
              c_d     = bus.mm_result;
              eoc_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = StIdle;
              issue   = 1'b0;
            end
            default: issue = 1'b0;
          endcase
        end
      end
    endcase

    // Operands are loaded on the same edge that raises mm_start and then held.
    if (issue) begin
      start_d = 1'b1;
      unique case (state_d)
        StPreM: begin a_d = m_d; b_d = k_d;  end
        StPreX: begin a_d = one; b_d = k_q;  end
        StSqr:  begin a_d = x_d; b_d = x_d;  end
        StMul:  begin a_d = x_d; b_d = mb_q; end
        StPost: begin a_d = x_d; b_d = one;  end
        default: start_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      p_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      x_q     <= '0;
      mb_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      i_q     <= '0;
      start_q <= 1'b0;
      eoc_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      p_q     <= p_d;
      e_q     <= e_d;
      m_q     <= m_d;
      k_q     <= k_d;
      x_q     <= x_d;
      mb_q    <= mb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      i_q     <= i_d;
      start_q <= start_d;
      eoc_q   <= eoc_d;
      busy_q  <= busy_d;
    end
  end

  // A pending request survives a freeze and is presented once ena returns.
  assign bus.mm_start = start_q & ena;
  assign bus.mm_a     = a_q;
  assign bus.mm_b     = b_q;
  assign bus.mm_n     = p_q;
  assign bus.rsa_c    = c_q;
  assign bus.eoc      = eoc_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rsa_mexp_ctrl.sv
// Directed bench for rsa_mexp_ctrl with a behavioural fixed-latency Montgomery multiplier.
module tb_rsa_mexp_ctrl;
  localparam int unsigned L = 10;

  typedef struct packed {
    logic [7:0]  p;
    logic [7:0]  e;
    logic [7:0]  m;
    logic [7:0]  k;
    logic [7:0]  exp_c;
    int unsigned ops;
  } vec_t;

  logic clk;
  logic rst;
  logic ena;
  int   checks = 0;
  int   failures = 0;
  int   n_start = 0;
  int   mdl_cnt = 0;
  logic [7:0] mdl_res = '0;
  vec_t vecs [6];

  rsa_mexp_ctrl_if #(.WIDTH(8)) bus ();

  rsa_mexp_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Montgomery product a*b*R^-1 mod n, R = 256.
  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] n);
    int unsigned prod;
    int unsigned nn;
    logic [7:0]  res;
    prod = int'(a) * int'(b);
    nn   = int'(n);
    res  = '0;
    for (int r = 0; r < int'(nn); r++) begin
      if (((int'(r) * 256) % nn) == (prod % nn)) res = 8'(r);
    end
    return res;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_cnt <= 0;
      bus.mm_done <= 1'b0;
      bus.mm_result <= '0;
    end else if (ena) begin
      bus.mm_done <= 1'b0;
      if (bus.mm_start) begin
        mdl_cnt <= L - 1;
        mdl_res <= mont(bus.mm_a, bus.mm_b, bus.mm_n);
      end else if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1) begin
          bus.mm_done <= 1'b1;
          bus.mm_result <= mdl_res;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && ena && bus.mm_start) n_start <= n_start + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    bus.rsa_p     = v.p;
    bus.rsa_e     = v.e;
    bus.rsa_m     = v.m;
    bus.rsa_const = v.k;
  endtask

  // Start one exponentiation and wait for eoc; optional freeze window and mid-run injection.
  task automatic run_vec(input vec_t v, input int freeze_at, input int inject_at);
    int edges;
    int base;
    bit done;
    set_inputs(v);
    bus.start_cmd = 1'b1;
    tick();
    bus.start_cmd = 1'b0;
    base  = n_start;
    edges = 0;
    done  = 1'b0;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("eoc_cleared", 32'(bus.eoc), 32'd0);
    while (!done && edges < 1000) begin
      tick();
      edges++;
      if (freeze_at != 0 && edges == freeze_at) ena = 1'b0;
      if (freeze_at != 0 && edges == freeze_at + 20) ena = 1'b1;
      if (inject_at != 0 && edges == inject_at) begin
        bus.rsa_m     = 8'h07;
        bus.start_cmd = 1'b1;
      end
      if (inject_at != 0 && edges == inject_at + 1) bus.start_cmd = 1'b0;
      if (bus.eoc) done = 1'b1;
    end
    chk("eoc_seen", 32'(done), 32'd1);
    chk("result", 32'(bus.rsa_c), 32'(v.exp_c));
    chk("eoc_cycle", 32'(edges), 32'(v.ops * (L + 1) + ((freeze_at != 0) ? 20 : 0)));
    chk("mm_start_count", 32'(n_start - base), 32'(v.ops));
    chk("busy_at_end", 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rsa_c"}, 32'(bus.rsa_c), 32'd0);
    chk({tag, "_eoc"}, 32'(bus.eoc), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_mm_start"}, 32'(bus.mm_start), 32'd0);
    chk({tag, "_mm_a"}, 32'(bus.mm_a), 32'd0);
    chk({tag, "_mm_b"}, 32'(bus.mm_b), 32'd0);
    chk({tag, "_mm_n"}, 32'(bus.mm_n), 32'd0);
  endtask

  initial begin
    int base;
    int guard;
    vecs[0] = '{p: 8'h3D, e: 8'h11, m: 8'h05, k: 8'h16, exp_c: 8'h24, ops: 13};
    vecs[1] = '{p: 8'h3D, e: 8'h00, m: 8'h05, k: 8'h16, exp_c: 8'h01, ops: 11};
    vecs[2] = '{p: 8'h3D, e: 8'h03, m: 8'h05, k: 8'h16, exp_c: 8'h03, ops: 13};
    vecs[3] = '{p: 8'h3D, e: 8'hFF, m: 8'h02, k: 8'h16, exp_c: 8'h0B, ops: 19};
    vecs[4] = '{p: 8'h0B, e: 8'h03, m: 8'h07, k: 8'h09, exp_c: 8'h02, ops: 13};
    vecs[5] = '{p: 8'hFB, e: 8'h08, m: 8'h02, k: 8'h19, exp_c: 8'h05, ops: 12};

    rst = 1'b1;
    ena = 1'b1;
    bus.start_cmd = 1'b0;
    bus.stop_cmd  = 1'b0;
    set_inputs(vecs[0]);
    tick();
    tick();
    chk_zero_outputs("reset");
    rst = 1'b0;
    tick();
    chk_zero_outputs("post_reset");

    for (int v = 0; v < 6; v++) run_vec(vecs[v], 0, 0);

    // Abort with a multiply in flight: DRAIN until mm_done, previous result kept.
    set_inputs(vecs[0]);
    bus.start_cmd = 1'b1;
    tick();
    bus.start_cmd = 1'b0;
    base  = n_start;
    guard = 0;
    while (n_start - base < 5 && guard < 200) begin
      tick();
      guard++;
    end
    chk("abort_reached_op5", 32'(n_start - base), 32'd5);
    tick();
    tick();
    bus.stop_cmd = 1'b1;
    tick();
    bus.stop_cmd = 1'b0;
    chk("drain_busy", 32'(bus.busy), 32'd1);
    guard = 0;
    while (!bus.mm_done && guard < 50) begin
      tick();
      guard++;
    end
    chk("drain_done_seen", 32'(bus.mm_done), 32'd1);
    chk("drain_busy_at_done", 32'(bus.busy), 32'd1);
    tick();
    chk("drain_busy_drop", 32'(bus.busy), 32'd0);
    chk("drain_eoc", 32'(bus.eoc), 32'd0);
    chk("drain_rsa_c_kept", 32'(bus.rsa_c), 32'h05);
    tick();
    chk("drain_no_new_start", 32'(n_start - base), 32'd5);
    run_vec(vecs[0], 0, 0);

    // Start while busy, with rsa_m changed mid-run, has no effect.
    run_vec(vecs[0], 0, 30);

    // Start and stop together in IDLE: stop wins.
    base = n_start;
    bus.start_cmd = 1'b1;
    bus.stop_cmd  = 1'b1;
    tick();
    bus.start_cmd = 1'b0;
    bus.stop_cmd  = 1'b0;
    chk("idle_startstop_busy", 32'(bus.busy), 32'd0);
    chk("idle_startstop_eoc", 32'(bus.eoc), 32'd1);
    tick();
    tick();
    chk("idle_startstop_no_mm", 32'(n_start - base), 32'd0);

    // Freeze for 20 cycles during a square.
    run_vec(vecs[0], 40, 0);

    // Asynchronous reset during the first MUL (op 7, edges 66..77).
    set_inputs(vecs[0]);
    bus.start_cmd = 1'b1;
    tick();
    bus.start_cmd = 1'b0;
    repeat (70) tick();
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    tick();
    rst = 1'b0;
    tick();
    run_vec(vecs[0], 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
